nn_phase_sequencer: RTL and testbench

- Parametrised successor to the network's phase controller; sequences forward-hidden, forward-output, backward-output and backward-hidden phases per sample.
- Supports train and validate modes and configurable phase lengths. Runs a batch of N samples per command, with start/busy/done handshake and abort.
- Sits between the top-level host control and the hidden/output layer datapaths. Drives per-phase enable levels and one-cycle phase-start strobes.

---
 rtl/nn_ctrl_pkg.sv | 28 ++
 rtl/nn_phase_sequencer_if.sv | 39 +++
 rtl/nn_phase_timer.sv | 32 +++
 rtl/nn_phase_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_nn_phase_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared types for the network phase controller: phase/mode enums and
// the bit positions used in the phase_start strobe vector.
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FH   = 3'd1,
        FO   = 3'd2,
        BO   = 3'd3,
        BH   = 3'd4,
        DONE = 3'd5
    } phase_e;

    typedef enum logic {
        TRAIN = 1'b0,
        VALID = 1'b1
    } mode_e;

    localparam int PHASE_FPH = 3;
    localparam int PHASE_FPO = 2;
    localparam int PHASE_BPH = 1;
    localparam int PHASE_BPO = 0;

    function automatic logic in_phase(phase_e s);
        return (s == FH) || (s == FO) || (s == BO) || (s == BH);
    endfunction

endpackage

// File: rtl/nn_phase_sequencer_if.sv
// Host-control and datapath-enable bundle of the phase sequencer.
// Handshake: start_* is honoured only while the sequencer is idle (busy low,
// no done cycle); abort is honoured only while busy; every output is a registered level or one-cycle pulse.
interface nn_phase_sequencer_if #(
    parameter int SAMP_W = 8
);
    import nn_ctrl_pkg::*;

    logic              start_train;
    logic              start_valid;
    logic              abort;
    logic [SAMP_W-1:0] num_samples;

    logic              fph;
    logic              fpo;
    logic              bph;
    logic              bpo;
    logic [3:0]        phase_start;
    logic              busy;
    logic [SAMP_W-1:0] sample_idx;
    logic              sample_done;
    logic              train_done;
    logic              valid_done;
    logic              aborted;
    phase_e            state;

    modport master (
        output start_train, start_valid, abort, num_samples,
        input  fph, fpo, bph, bpo, phase_start, busy, sample_idx,
        input  sample_done, train_done, valid_done, aborted, state
    );

    modport slave (
        input  start_train, start_valid, abort, num_samples,
        output fph, fpo, bph, bpo, phase_start, busy, sample_idx,
        output sample_done, train_done, valid_done, aborted, state
    );

endinterface

// File: rtl/nn_phase_timer.sv
// Per-phase cycle counter: cleared on load, otherwise counts up; tc flags
// the final cycle of the running phase.
module nn_phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] cnt_next,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = load ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_next = cnt_d;
    assign tc       = (cnt_q == last);

endmodule

// File: rtl/nn_phase_sequencer.sv
// Batch phase sequencer: walks FH/FO(/BO/BH) per sample, drives phase
// enables, start strobes, done/abort pulses; all outputs registered.
module nn_phase_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int L_FH   = 5,
    parameter int L_FO   = 16,
    parameter int L_BO   = 16,
    parameter int L_BH   = 16,
    parameter int SAMP_W = 8,
    parameter int CNT_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    nn_phase_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_FH = CNT_W'(L_FH - 1);
    localparam logic [CNT_W-1:0] LAST_FO = CNT_W'(L_FO - 1);
    localparam logic [CNT_W-1:0] LAST_BO = CNT_W'(L_BO - 1);
    localparam logic [CNT_W-1:0] LAST_BH = CNT_W'(L_BH - 1);

    function automatic logic [CNT_W-1:0] last_of(phase_e s);
        case (s)
            FH:      return LAST_FH;
            FO:      return LAST_FO;
            BO:      return LAST_BO;
            BH:      return LAST_BH;
            default: return '0;
        endcase
    endfunction

    phase_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [SAMP_W-1:0] n_last_q, n_last_d;
    logic [SAMP_W-1:0] idx_q, idx_d;
    logic              fph_q, fph_d, fpo_q, fpo_d, bph_q, bph_d, bpo_q, bpo_d;
    logic [3:0]        ps_q, ps_d;
    logic              busy_q, busy_d;
    logic              sdone_q, sdone_d;
    logic              tdone_q, tdone_d;
    logic              vdone_q, vdone_d;
    logic              abrt_q, abrt_d;

    logic              phase_enter;
    logic              sample_end;
    logic              tmr_load;
    logic [CNT_W-1:0]  cnt_next;
    logic              tc;

    nn_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .last     (last_of(state_q)),
        .cnt_next (cnt_next),
        .tc       (tc)
    );

    // Next-state: sample_end is the end-of-sample decision, resolved in the
    // same cycle so the next sample's FH follows with no gap.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        n_last_d    = n_last_q;
        idx_d       = idx_q;
        phase_enter = 1'b0;
        sample_end  = 1'b0;
        abrt_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.abort && (bus.start_train || bus.start_valid)) begin
                    mode_d      = bus.start_train ? TRAIN : VALID;
                    n_last_d    = (bus.num_samples == '0) ? '0
                                : bus.num_samples - SAMP_W'(1);
                    idx_d       = '0;
                    state_d     = FH;
                    phase_enter = 1'b1;
                end
            end
            FH: begin
                if (tc) begin
                    state_d     = FO;
                    phase_enter = 1'b1;
                end
            end
            FO: begin
                if (tc) begin
                    if (mode_q == TRAIN) begin
                        state_d     = BO;
                        phase_enter = 1'b1;
                    end else begin
                        sample_end = 1'b1;
                    end
                end
            end
            BO: begin
                if (tc) begin
                    state_d     = BH;
                    phase_enter = 1'b1;
                end
            end
            BH: begin
                if (tc) begin
                    sample_end = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (sample_end) begin
            if (idx_q == n_last_q) begin
                state_d = DONE;
            end else begin
                idx_d       = idx_q + SAMP_W'(1);
                state_d     = FH;
                phase_enter = 1'b1;
            end
        end

        // Abort overrides everything, including a completing final phase.
        if (bus.abort && in_phase(state_q)) begin
            state_d     = IDLE;
            idx_d       = '0;
            phase_enter = 1'b0;
            abrt_d      = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they land in the flops
    // together with it.
    always_comb begin
        tmr_load = phase_enter || !in_phase(state_d);
        fph_d    = (state_d == FH);
        fpo_d    = (state_d == FO);
        bph_d    = (state_d == BH);
        bpo_d    = (state_d == BO);
        ps_d     = '0;
        ps_d[PHASE_FPH] = phase_enter && (state_d == FH);
        ps_d[PHASE_FPO] = phase_enter && (state_d == FO);
        ps_d[PHASE_BPH] = phase_enter && (state_d == BH);
        ps_d[PHASE_BPO] = phase_enter && (state_d == BO);
        busy_d   = in_phase(state_d);
        sdone_d  = (((state_d == FO) && (mode_d == VALID)) || (state_d == BH))
                 && (cnt_next == last_of(state_d));
        tdone_d  = (state_d == DONE) && (mode_q == TRAIN);
        vdone_d  = (state_d == DONE) && (mode_q == VALID);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= TRAIN;
            n_last_q <= '0;
            idx_q    <= '0;
            fph_q    <= 1'b0;
            fpo_q    <= 1'b0;
            bph_q    <= 1'b0;
            bpo_q    <= 1'b0;
            ps_q     <= '0;
            busy_q   <= 1'b0;
            sdone_q  <= 1'b0;
            tdone_q  <= 1'b0;
            vdone_q  <= 1'b0;
            abrt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            n_last_q <= n_last_d;
            idx_q    <= idx_d;
            fph_q    <= fph_d;
            fpo_q    <= fpo_d;
            bph_q    <= bph_d;
            bpo_q    <= bpo_d;
            ps_q     <= ps_d;
            busy_q   <= busy_d;
            sdone_q  <= sdone_d;
            tdone_q  <= tdone_d;
            vdone_q  <= vdone_d;
            abrt_q   <= abrt_d;
        end
    end

    assign bus.fph         = fph_q;
    assign bus.fpo         = fpo_q;
    assign bus.bph         = bph_q;
    assign bus.bpo         = bpo_q;
    assign bus.phase_start = ps_q;
    assign bus.busy        = busy_q;
    assign bus.sample_idx  = idx_q;
    assign bus.sample_done = sdone_q;
    assign bus.train_done  = tdone_q;
    assign bus.valid_done  = vdone_q;
    assign bus.aborted     = abrt_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_nn_phase_sequencer.sv
// Directed bench for nn_phase_sequencer: per-cycle traces of whole batches
// compared against a hand-computed vector table and per-batch pulse counts.
module tb_nn_phase_sequencer;
    import nn_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] en;    // {fph,fpo,bph,bpo}
        logic [3:0] ps;
        logic       busy;
        logic [7:0] idx;
        logic       sd;
        logic       td;
        logic       vd;
        logic       ab;
    } obs_t;

    typedef struct {
        int   scen;
        int   cyc;
        obs_t exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    obs_t trace [0:127];
    vec_t vecs[$];

    nn_phase_sequencer_if #(.SAMP_W(8)) bus ();

    nn_phase_sequencer #(
        .L_FH(5), .L_FO(16), .L_BO(16), .L_BH(16), .SAMP_W(8), .CNT_W(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic obs_t mk(logic [3:0] en, logic [3:0] ps, logic busy,
                                logic [7:0] idx, logic sd, logic td,
                                logic vd, logic ab);
        obs_t o;
        o.en = en; o.ps = ps; o.busy = busy; o.idx = idx;
        o.sd = sd; o.td = td; o.vd = vd; o.ab = ab;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk({bus.fph, bus.fpo, bus.bph, bus.bpo}, bus.phase_start,
                  bus.busy, bus.sample_idx, bus.sample_done, bus.train_done,
                  bus.valid_done, bus.aborted);
    endfunction

    task automatic add(input int scen, input int cyc, input obs_t e);
        vec_t v;
        v.scen = scen; v.cyc = cyc; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; trace[c] holds outputs of cycle c, where the
    // start is sampled at rising edge 0.
    task automatic run(input logic st, input logic sv, input int n, input int ncyc,
                       input int abort_at, input int rep_every, input int mid_n);
        bus.num_samples = n[7:0];
        bus.start_train = st;
        bus.start_valid = sv;
        bus.abort       = (abort_at == 0);
        trace[0] = sample();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            trace[c] = sample();
            bus.start_train = 1'b0;
            bus.start_valid = 1'b0;
            if (rep_every > 0 && (c % rep_every) == 0 && c <= 53) begin
                bus.start_train = 1'b1;
                bus.start_valid = 1'b1;
            end
            bus.abort = (c == abort_at);
            if (mid_n >= 0 && c == 10) bus.num_samples = mid_n[7:0];
        end
        bus.abort = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_vecs(input int scen);
        foreach (vecs[i]) begin
            if (vecs[i].scen == scen)
                chk($sformatf("s%0d_cyc%0d", scen, vecs[i].cyc),
                    32'(trace[vecs[i].cyc]), 32'(vecs[i].exp));
        end
    endtask

    task automatic check_counts(input int scen, input int ncyc,
                                input int e_fph, input int e_fpo, input int e_bph,
                                input int e_bpo, input int e_sd, input int e_td,
                                input int e_vd, input int e_ab);
        int c_fph, c_fpo, c_bph, c_bpo, c_sd, c_td, c_vd, c_ab, c_multi;
        c_fph = 0; c_fpo = 0; c_bph = 0; c_bpo = 0;
        c_sd = 0; c_td = 0; c_vd = 0; c_ab = 0; c_multi = 0;
        for (int c = 1; c <= ncyc; c++) begin
            c_fph += int'(trace[c].en[3]);
            c_fpo += int'(trace[c].en[2]);
            c_bph += int'(trace[c].en[1]);
            c_bpo += int'(trace[c].en[0]);
            c_sd  += int'(trace[c].sd);
            c_td  += int'(trace[c].td);
            c_vd  += int'(trace[c].vd);
            c_ab  += int'(trace[c].ab);
            if ($countones(trace[c].en) > 1) c_multi++;
        end
        chk($sformatf("s%0d_n_fph", scen), 32'(c_fph), 32'(e_fph));
        chk($sformatf("s%0d_n_fpo", scen), 32'(c_fpo), 32'(e_fpo));
        chk($sformatf("s%0d_n_bph", scen), 32'(c_bph), 32'(e_bph));
        chk($sformatf("s%0d_n_bpo", scen), 32'(c_bpo), 32'(e_bpo));
        chk($sformatf("s%0d_n_sample_done", scen), 32'(c_sd), 32'(e_sd));
        chk($sformatf("s%0d_n_train_done", scen), 32'(c_td), 32'(e_td));
        chk($sformatf("s%0d_n_valid_done", scen), 32'(c_vd), 32'(e_vd));
        chk($sformatf("s%0d_n_aborted", scen), 32'(c_ab), 32'(e_ab));
        chk($sformatf("s%0d_enables_exclusive", scen), 32'(c_multi), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        obs_t z;
        n_total = 0;
        n_pass  = 0;
        z = '0;

        // S1: train, N=1
        add(1, 0,  z);
        add(1, 1,  mk(4'b1000, 4'b1000, 1, 0, 0, 0, 0, 0));
        add(1, 5,  mk(4'b1000, 4'b0000, 1, 0, 0, 0, 0, 0));
        add(1, 6,  mk(4'b0100, 4'b0100, 1, 0, 0, 0, 0, 0));
        add(1, 21, mk(4'b0100, 4'b0000, 1, 0, 0, 0, 0, 0));
        add(1, 22, mk(4'b0001, 4'b0001, 1, 0, 0, 0, 0, 0));
        add(1, 37, mk(4'b0001, 4'b0000, 1, 0, 0, 0, 0, 0));
        add(1, 38, mk(4'b0010, 4'b0010, 1, 0, 0, 0, 0, 0));
        add(1, 53, mk(4'b0010, 4'b0000, 1, 0, 1, 0, 0, 0));
        add(1, 54, mk(4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0));
        add(1, 55, z);
        // S2: valid, N=3 (num_samples rewritten mid-batch)
        add(2, 1,  mk(4'b1000, 4'b1000, 1, 0, 0, 0, 0, 0));
        add(2, 6,  mk(4'b0100, 4'b0100, 1, 0, 0, 0, 0, 0));
        add(2, 21, mk(4'b0100, 4'b0000, 1, 0, 1, 0, 0, 0));
        add(2, 22, mk(4'b1000, 4'b1000, 1, 1, 0, 0, 0, 0));
        add(2, 42, mk(4'b0100, 4'b0000, 1, 1, 1, 0, 0, 0));
        add(2, 43, mk(4'b1000, 4'b1000, 1, 2, 0, 0, 0, 0));
        add(2, 63, mk(4'b0100, 4'b0000, 1, 2, 1, 0, 0, 0));
        add(2, 64, mk(4'b0000, 4'b0000, 0, 2, 0, 0, 1, 0));
        add(2, 65, mk(4'b0000, 4'b0000, 0, 2, 0, 0, 0, 0));
        // S3: both starts, N=2 -> train
        add(3, 53,  mk(4'b0010, 4'b0000, 1, 0, 1, 0, 0, 0));
        add(3, 54,  mk(4'b1000, 4'b1000, 1, 1, 0, 0, 0, 0));
        add(3, 106, mk(4'b0010, 4'b0000, 1, 1, 1, 0, 0, 0));
        add(3, 107, mk(4'b0000, 4'b0000, 0, 1, 0, 1, 0, 0));
        add(3, 108, mk(4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0));
        // S4: abort during bpo
        add(4, 30, mk(4'b0001, 4'b0000, 1, 0, 0, 0, 0, 0));
        add(4, 31, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1));
        // S5: fresh start right after abort, N=0, repeated starts -> same as S1
        foreach (vecs[i]) if (vecs[i].scen == 1 && vecs[i].cyc > 0) add(5, vecs[i].cyc, vecs[i].exp);
        // S6: abort together with start in IDLE
        add(6, 1, z);
        add(6, 2, z);
        // S7: abort on last FO cycle of a valid batch
        add(7, 21, mk(4'b0100, 4'b0000, 1, 0, 1, 0, 0, 0));
        add(7, 22, mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1));
        // S8/S9: async reset mid-FO, then restart
        add(8, 10, mk(4'b0100, 4'b0000, 1, 0, 0, 0, 0, 0));
        add(9, 0,  z);
        add(9, 1,  mk(4'b1000, 4'b1000, 1, 0, 0, 0, 0, 0));
        add(9, 2,  mk(4'b1000, 4'b0000, 1, 0, 0, 0, 0, 0));

        // clock/reset
        rst = 1'b1;
        bus.start_train = 1'b0;
        bus.start_valid = 1'b0;
        bus.abort       = 1'b0;
        bus.num_samples = 8'd0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(sample()), 32'd0);
        chk("reset_state", 32'(bus.state), 32'(IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(1'b1, 1'b0, 1, 58, -1, 0, -1);
        check_vecs(1);
        check_counts(1, 58, 5, 16, 16, 16, 1, 1, 0, 0);
        repeat (3) @(negedge clk);

        run(1'b0, 1'b1, 3, 70, -1, 0, 1);
        check_vecs(2);
        check_counts(2, 70, 15, 48, 0, 0, 3, 0, 1, 0);
        repeat (3) @(negedge clk);

        run(1'b1, 1'b1, 2, 112, -1, 0, 5);
        check_vecs(3);
        check_counts(3, 112, 10, 32, 32, 32, 2, 1, 0, 0);
        repeat (3) @(negedge clk);

        run(1'b1, 1'b0, 2, 31, 30, 0, -1);
        check_vecs(4);
        check_counts(4, 31, 5, 16, 0, 9, 0, 0, 0, 1);
        run(1'b1, 1'b0, 0, 58, -1, 7, -1);
        check_vecs(5);
        check_counts(5, 58, 5, 16, 16, 16, 1, 1, 0, 0);
        repeat (3) @(negedge clk);

        run(1'b0, 1'b1, 1, 8, 0, 0, -1);
        check_vecs(6);
        check_counts(6, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        run(1'b0, 1'b1, 1, 26, 21, 0, -1);
        check_vecs(7);
        check_counts(7, 26, 5, 16, 0, 0, 1, 0, 0, 1);
        repeat (3) @(negedge clk);

        run(1'b0, 1'b1, 1, 10, -1, 0, -1);
        check_vecs(8);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", 32'(sample()), 32'd0);
        chk("async_reset_state", 32'(bus.state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 1'b1, 1, 3, -1, 0, -1);
        check_vecs(9);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
